// File: rtl/mcu_el2_pmp_boot_seq_pkg.sv
// mcu_el2_pmp_boot_seq_pkg: shared record/state types and PMP CSR map constants
package mcu_el2_pmp_boot_seq_pkg;
  localparam logic [11:0] PMPCFG_BASE = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
  localparam logic [11:0] PMPADDR_END = 12'h3EF;
  localparam logic [31:0] PMPCFG_MASK = 32'h9F9F_9F9F;
  localparam logic [31:0] PMPADDR_MASK = 32'h3FFF_FFFF;
  typedef struct packed {
    logic        last;
    logic        nochk;
    logic [11:0] csr_addr;
    logic [31:0] data;
  } mcu_el2_pmp_seq_rec_t;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_VERIFY, S_NEXT, S_DONE, S_ERR
  } mcu_el2_pmp_seq_state_t;
endpackage

// File: rtl/mcu_el2_pmp_boot_seq_if.sv
// mcu_el2_pmp_boot_seq_if: table read port plus PMP CSR write/readback port
interface mcu_el2_pmp_boot_seq_if
  import mcu_el2_pmp_boot_seq_pkg::*;
#(parameter int TBL_AW = 5) ();
  logic                 tbl_rd_en;
  logic [TBL_AW-1:0]    tbl_rd_addr;
  mcu_el2_pmp_seq_rec_t tbl_rd_data;
  logic                 core_csr_wen;
  logic                 seq_csr_wen;
  logic [11:0]          seq_csr_wraddr;
  logic [31:0]          seq_csr_wrdata;
  logic                 seq_csr_rden;
  logic [11:0]          seq_csr_rdaddr;
  logic [31:0]          pmp_rddata;
  modport master (
    output tbl_rd_en, tbl_rd_addr, seq_csr_wen, seq_csr_wraddr, seq_csr_wrdata,
           seq_csr_rden, seq_csr_rdaddr,
    input  tbl_rd_data, core_csr_wen, pmp_rddata
  );
  modport slave (
    input  tbl_rd_en, tbl_rd_addr, seq_csr_wen, seq_csr_wraddr, seq_csr_wrdata,
           seq_csr_rden, seq_csr_rdaddr,
    output tbl_rd_data, core_csr_wen, pmp_rddata
  );
endinterface

// File: rtl/mcu_el2_pmp_boot_seq_addr_chk.sv
// mcu_el2_pmp_boot_seq_addr_chk: PMP CSR address legality and readback compare mask
module mcu_el2_pmp_boot_seq_addr_chk
  import mcu_el2_pmp_boot_seq_pkg::*;
#(parameter int PMP_ENTRIES = 16) (
  input  logic [11:0] csr_addr,
  output logic        legal,
  output logic [31:0] mask
);
  logic       is_cfg;
  logic       is_addr;
  logic [5:0] idx;
  // 0x3B0..0x3EF folds onto entry index 0..63
  assign idx = {csr_addr[5:4] - 2'b11, csr_addr[3:0]};
  assign is_cfg = (csr_addr[11:4] == PMPCFG_BASE[11:4]) && (32'(csr_addr[3:0]) < 32'(PMP_ENTRIES / 4));
  assign is_addr = (csr_addr >= PMPADDR_BASE) && (csr_addr <= PMPADDR_END) && (32'(idx) < 32'(PMP_ENTRIES));
  assign legal = is_cfg | is_addr;
  assign mask = is_cfg ? PMPCFG_MASK : PMPADDR_MASK;
endmodule

// File: rtl/mcu_el2_pmp_boot_seq.sv
// mcu_el2_pmp_boot_seq: boot-time PMP table walker with per-record readback check
module mcu_el2_pmp_boot_seq
  import mcu_el2_pmp_boot_seq_pkg::*;
#(
  parameter int PMP_ENTRIES = 16,
  parameter int TBL_DEPTH = 32,
  parameter int TBL_AW = $clog2(TBL_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          start,
  mcu_el2_pmp_boot_seq_if.master        bus,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [TBL_AW-1:0]             err_idx
);
  mcu_el2_pmp_seq_state_t state, state_nxt;
  mcu_el2_pmp_seq_rec_t   rec;
  logic [TBL_AW-1:0]      ptr;
  logic [TBL_AW-1:0]      err_idx_q;
  logic [11:0]            chk_addr;
  logic                   legal;
  logic [31:0]            mask;
  logic                   idle;
  logic                   match;
  logic                   last_rec;
  // legality is judged on the fresh table word, the mask on the latched record
  assign chk_addr = (state == S_WAIT) ? bus.tbl_rd_data.csr_addr : rec.csr_addr;
  mcu_el2_pmp_boot_seq_addr_chk #(.PMP_ENTRIES(PMP_ENTRIES)) u_addr_chk (
    .csr_addr (chk_addr),
    .legal    (legal),
    .mask     (mask)
  );
  assign idle = state inside {S_IDLE, S_DONE, S_ERR};
  assign match = ((bus.pmp_rddata ^ rec.data) & mask) == '0;
  assign last_rec = rec.last | (ptr == TBL_AW'(TBL_DEPTH - 1));
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state <= S_IDLE;
      ptr <= '0;
      rec <= '0;
      err_idx_q <= '0;
    end else begin
      state <= state_nxt;
      if (idle && start) ptr <= '0;
      if (idle && start) err_idx_q <= '0;
      if (state == S_WAIT) rec <= bus.tbl_rd_data;
      if (state == S_NEXT && !last_rec) ptr <= ptr + 1'b1;
      if (state_nxt == S_ERR && state != S_ERR) err_idx_q <= ptr;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: state_nxt = start ? S_FETCH : state;
      S_FETCH:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = legal ? S_WRITE : S_ERR;
      S_WRITE:  state_nxt = bus.core_csr_wen ? S_WRITE : (rec.nochk ? S_NEXT : S_VERIFY);
      S_VERIFY: state_nxt = bus.core_csr_wen ? S_VERIFY : (match ? S_NEXT : S_ERR);
      S_NEXT:   state_nxt = last_rec ? S_DONE : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = !idle;
    done = state == S_DONE;
    err = state == S_ERR;
    err_idx = err_idx_q;
    bus.tbl_rd_en = state == S_FETCH;
    bus.tbl_rd_addr = ptr;
    bus.seq_csr_wen = (state == S_WRITE) && !bus.core_csr_wen;
    bus.seq_csr_wraddr = (state == S_WRITE) ? rec.csr_addr : '0;
    bus.seq_csr_wrdata = (state == S_WRITE) ? rec.data : '0;
    bus.seq_csr_rden = (state == S_VERIFY) && !bus.core_csr_wen;
    bus.seq_csr_rdaddr = (state == S_VERIFY) ? rec.csr_addr : '0;
  end
endmodule
